// File: rtl/id_scoreboard_pkg.sv
// Shared definitions for the decode-stage register scoreboard.
// It holds the default geometry, the counter and register-id types, and a
// helper that sizes the per-register retire-hit count.
package id_scoreboard_pkg;

  localparam int SB_NUM_REGS  = 32;
  localparam int SB_REGID_W   = 5;
  localparam int SB_NUM_SRC   = 2;
  localparam int SB_NUM_RET   = 2;
  localparam int SB_CNT_W     = 2;
  localparam int SB_WB_BYPASS = 1;

  typedef logic [SB_CNT_W-1:0]   sb_cnt_t;
  typedef logic [SB_REGID_W-1:0] regid_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;

  // Width needed to count 0..n matching retire ports.
  function automatic int sb_hit_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Outstanding-write counter for one architectural register.
// Ports:
//   clk, rst   core clock, synchronous active-high reset (clears the count)
//   inc        one new in-flight writer recorded this cycle
//   dec        number of retire/kill ports that hit this register this cycle
//   cnt        registered outstanding-write count
//   underflow  combinational: this cycle retires more writers than exist
// Increment and decrement are applied as one net update. On underflow the
// count clamps to zero; an over-increment saturates instead of wrapping.
module sb_counter #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

  logic [SUM_W-1:0] total;
  logic [SUM_W-1:0] dec_x;
  logic [SUM_W-1:0] cnt_max;
  logic [SUM_W-1:0] diff;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    total     = SUM_W'(cnt) + SUM_W'(inc);
    dec_x     = SUM_W'(dec);
    cnt_max   = SUM_W'({CNT_W{1'b1}});
    diff      = total - dec_x;
    underflow = (dec_x > total);
    if (underflow) begin
      cnt_next = '0;
    end else if (diff > cnt_max) begin
      cnt_next = '1;
    end else begin
      cnt_next = diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard with per-register outstanding-write
// counters, so multi-cycle producers stall dependent readers until retire.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   id_valid        valid instruction present in ID
//   id_stall        external stall; blocks issue
//   id_flush        ID instruction squashed; blocks issue (counters untouched)
//   src_read        per-source "operand used" flags
//   src_regid       packed source register ids (source i at [i*REGID_W +: REGID_W])
//   dst_write       instruction writes rd
//   dst_regid       destination register id
//   ret_valid       per-port retire (WB) or kill (flush) of one in-flight write
//   ret_regid       packed register ids of the retire ports
//   hazard_stall    ID must hold: RAW pending or WAW counter full
//   issue_fire      instruction issued and recorded this cycle
//   busy_vec        bit r set while register r has outstanding writes
//   err_underflow   sticky: a retire hit a register with no outstanding write
// Handshake: ID offers an instruction with id_valid; it is accepted
// (issue_fire) only in a cycle where hazard_stall, id_stall and id_flush are
// all low. While not accepted, ID holds the instruction and re-presents it.
// Register 0 is never tracked: it never stalls, never counts, and retires
// naming it are ignored.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = SB_NUM_REGS,
  parameter int REGID_W   = SB_REGID_W,
  parameter int NUM_SRC   = SB_NUM_SRC,
  parameter int NUM_RET   = SB_NUM_RET,
  parameter int CNT_W     = SB_CNT_W,
  parameter int WB_BYPASS = SB_WB_BYPASS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic                       id_stall,
  input  logic                       id_flush,
  input  logic [NUM_SRC-1:0]         src_read,
  input  logic [NUM_SRC*REGID_W-1:0] src_regid,
  input  logic                       dst_write,
  input  logic [REGID_W-1:0]         dst_regid,
  input  logic [NUM_RET-1:0]         ret_valid,
  input  logic [NUM_RET*REGID_W-1:0] ret_regid,
  output logic                       hazard_stall,
  output logic                       issue_fire,
  output logic [NUM_REGS-1:0]        busy_vec,
  output logic                       err_underflow
);

  localparam int HIT_W = sb_hit_width(NUM_RET);
  localparam int CMP_W = ((CNT_W > HIT_W) ? CNT_W : HIT_W) + 1;

  logic [CNT_W-1:0]    cnt_arr [NUM_REGS];
  logic [HIT_W-1:0]    hits    [NUM_REGS];
  logic [NUM_REGS-1:0] uf_vec;
  logic [NUM_SRC-1:0]  raw;
  logic                waw;

  // Number of retire ports naming each register this cycle.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      hits[r] = '0;
      for (int p = 0; p < NUM_RET; p++) begin
        if (r != 0 && ret_valid[p] &&
            ret_regid[p*REGID_W +: REGID_W] == REGID_W'(r)) begin
          hits[r] = hits[r] + HIT_W'(1);
        end
      end
    end
  end

  // RAW: a read of a register with outstanding writes stalls, unless every
  // outstanding write retires this cycle and the regfile writes through.
  always_comb begin
    logic [REGID_W-1:0] s_id;
    logic [CNT_W-1:0]   s_cnt;
    logic [HIT_W-1:0]   s_hit;
    raw = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_id   = src_regid[i*REGID_W +: REGID_W];
      s_cnt  = cnt_arr[s_id];
      s_hit  = hits[s_id];
      raw[i] = src_read[i] && (s_id != '0) && (s_cnt != '0) &&
               !((WB_BYPASS != 0) && (CMP_W'(s_cnt) == CMP_W'(s_hit)));
    end
  end

  // WAW: a full counter would wrap; only a retire on the same register this
  // cycle frees a slot for the new writer.
  always_comb begin
    waw = dst_write && (dst_regid != '0) &&
          (cnt_arr[dst_regid] == {CNT_W{1'b1}}) && (hits[dst_regid] == '0);
  end

  assign hazard_stall = id_valid && ((|raw) || waw);
  assign issue_fire   = id_valid && !hazard_stall && !id_stall && !id_flush;

  assign cnt_arr[0] = '0;
  assign uf_vec[0]  = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    logic inc;
    assign inc = issue_fire && dst_write && (dst_regid == REGID_W'(g));

    sb_counter #(
      .CNT_W (CNT_W),
      .DEC_W (HIT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc),
      .dec       (hits[g]),
      .cnt       (cnt_arr[g]),
      .underflow (uf_vec[g])
    );
  end

  // Derived purely from the counter flops, so it shows the post-edge state.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt_arr[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (|uf_vec) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_stall, id_flush;
  logic [1:0]  src_read;
  logic [9:0]  src_regid;
  logic        dst_write;
  logic [4:0]  dst_regid;
  logic [1:0]  ret_valid;
  logic [9:0]  ret_regid;
  logic        hazard_stall, issue_fire, err_underflow;
  logic [NR-1:0] busy_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state: outstanding writes per register and sticky error.
  int cnt_m [NR];
  int hits_m [NR];
  bit err_m;
  bit exp_stall, exp_fire;

  // clock / reset
  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_stall      (id_stall),
    .id_flush      (id_flush),
    .src_read      (src_read),
    .src_regid     (src_regid),
    .dst_write     (dst_write),
    .dst_regid     (dst_regid),
    .ret_valid     (ret_valid),
    .ret_regid     (ret_regid),
    .hazard_stall  (hazard_stall),
    .issue_fire    (issue_fire),
    .busy_vec      (busy_vec),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    id_valid = 0; id_stall = 0; id_flush = 0;
    src_read = '0; src_regid = '0; dst_write = 0; dst_regid = '0;
    ret_valid = '0; ret_regid = '0;
  endtask

  task automatic set_issue(input bit v, input bit dw, input int d,
                           input bit [1:0] sr, input int s0, input int s1);
    id_valid = v; dst_write = dw; dst_regid = 5'(d);
    src_read = sr; src_regid = {5'(s1), 5'(s0)};
  endtask

  task automatic set_ret(input bit [1:0] v, input int r0, input int r1);
    ret_valid = v; ret_regid = {5'(r1), 5'(r0)};
  endtask

  // Model: outputs from the rules, with registers as plain integer counts.
  task automatic eval_model();
    bit raw_any, waw;
    int s, d;
    for (int r = 0; r < NR; r++) hits_m[r] = 0;
    for (int p = 0; p < 2; p++) begin
      int id = int'(ret_regid[p*5 +: 5]);
      if (ret_valid[p] && id != 0) hits_m[id]++;
    end
    raw_any = 0;
    for (int i = 0; i < 2; i++) begin
      s = int'(src_regid[i*5 +: 5]);
      if (src_read[i] && s != 0 && cnt_m[s] != 0 &&
          !(SB_WB_BYPASS != 0 && cnt_m[s] == hits_m[s])) raw_any = 1;
    end
    d = int'(dst_regid);
    waw = dst_write && d != 0 && cnt_m[d] == int'(SB_CNT_MAX) && hits_m[d] == 0;
    exp_stall = id_valid && (raw_any || waw);
    exp_fire  = id_valid && !exp_stall && !id_stall && !id_flush;
  endtask

  // scoreboard compare: every cycle, away from the clock edge
  task automatic settle();
    logic [NR-1:0] exp_busy;
    #1;
    eval_model();
    for (int r = 0; r < NR; r++) exp_busy[r] = (cnt_m[r] != 0);
    chk("hazard_stall", 64'(hazard_stall), 64'(exp_stall));
    chk("issue_fire", 64'(issue_fire), 64'(exp_fire));
    chk("busy_vec", 64'(busy_vec), 64'(exp_busy));
    chk("err_underflow", 64'(err_underflow), 64'(err_m));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NR; r++) cnt_m[r] = 0;
      err_m = 0;
    end else begin
      for (int r = 1; r < NR; r++) begin
        int n = cnt_m[r] - hits_m[r];
        if (exp_fire && dst_write && int'(dst_regid) == r) n++;
        if (n < 0) begin
          n = 0;
          err_m = 1;
        end
        cnt_m[r] = n;
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    for (int r = 0; r < NR; r++) cnt_m[r] = 0;
    err_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // reset state
    settle();
    chk("reset_busy", 64'(busy_vec), 64'd0);
    chk("reset_err", 64'(err_underflow), 64'd0);
    chk("reset_stall", 64'(hazard_stall), 64'd0);
    advance();

    // 1: load x5, dependent add stalls until x5 retires (bypass releases it)
    set_issue(1, 1, 5, 2'b00, 0, 0);
    settle(); chk("t1_load_fire", 64'(issue_fire), 64'd1); advance();
    set_issue(1, 0, 0, 2'b01, 5, 0);
    settle(); chk("t1_stall_T1", 64'(hazard_stall), 64'd1); advance();
    settle(); chk("t1_stall_T2", 64'(hazard_stall), 64'd1); advance();
    set_ret(2'b01, 5, 0);
    settle();
    chk("t1_stall_T3", 64'(hazard_stall), 64'd0);
    chk("t1_fire_T3", 64'(issue_fire), 64'd1);
    advance();
    clear_inputs();
    settle(); chk("t1_busy5", 64'(busy_vec[5]), 64'd0); advance();

    // 2: three writers to x7 fill the counter; 4th waits for a retire
    set_issue(1, 1, 7, 2'b00, 0, 0);
    repeat (3) tick();
    settle(); chk("t2_waw_stall", 64'(hazard_stall), 64'd1); advance();
    set_ret(2'b01, 7, 0);
    settle(); chk("t2_waw_fire", 64'(issue_fire), 64'd1); advance();
    clear_inputs();
    chk("t2_model_cnt7", 64'(cnt_m[7]), 64'd3);
    settle(); chk("t2_busy7", 64'(busy_vec[7]), 64'd1); advance();
    set_ret(2'b11, 7, 7); tick();
    set_ret(2'b01, 7, 0); tick();
    clear_inputs();
    settle(); chk("t2_drained", 64'(busy_vec[7]), 64'd0); advance();

    // 3: issue and retire x9 in the same cycle keeps the count at 1
    set_issue(1, 1, 9, 2'b00, 0, 0); tick();
    set_ret(2'b01, 9, 0); tick();
    clear_inputs();
    settle(); chk("t3_busy9", 64'(busy_vec[9]), 64'd1); advance();
    set_ret(2'b10, 0, 9); tick();
    clear_inputs();
    settle(); chk("t3_busy9_clear", 64'(busy_vec[9]), 64'd0); advance();

    // 4: double retire of x4, then a retire at zero sets the sticky error
    set_issue(1, 1, 4, 2'b00, 0, 0); repeat (2) tick();
    clear_inputs();
    set_ret(2'b11, 4, 4); tick();
    clear_inputs();
    settle();
    chk("t4_busy4", 64'(busy_vec[4]), 64'd0);
    chk("t4_no_err", 64'(err_underflow), 64'd0);
    advance();
    set_ret(2'b01, 4, 0); tick();
    clear_inputs();
    settle(); chk("t4_err_set", 64'(err_underflow), 64'd1); advance();
    settle();
    chk("t4_err_sticky", 64'(err_underflow), 64'd1);
    chk("t4_busy4_zero", 64'(busy_vec[4]), 64'd0);
    advance();

    // 5: x0 traffic never stalls nor shows busy
    for (int k = 0; k < 4; k++) begin
      set_issue(1, 1, 0, 2'b11, 0, 0);
      set_ret(2'(k), 0, 0);
      settle();
      chk("t5_no_stall", 64'(hazard_stall), 64'd0);
      chk("t5_busy0", 64'(busy_vec[0]), 64'd0);
      advance();
    end

    // 6: reset with live counters and a stalled reader
    clear_inputs();
    set_issue(1, 1, 12, 2'b00, 0, 0); tick();
    set_issue(1, 0, 0, 2'b01, 12, 0);
    rst = 1; tick();
    rst = 0;
    settle();
    chk("t6_busy", 64'(busy_vec), 64'd0);
    chk("t6_err", 64'(err_underflow), 64'd0);
    chk("t6_no_stall", 64'(hazard_stall), 64'd0);
    advance();

    // randomized traffic over a small register window
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      id_stall  = ($urandom_range(0, 7) == 0);
      id_flush  = ($urandom_range(0, 15) == 0);
      src_read  = 2'($urandom_range(0, 3));
      src_regid = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      dst_write = ($urandom_range(0, 1) == 1);
      dst_regid = 5'($urandom_range(0, 7));
      for (int p = 0; p < 2; p++) begin
        int id = $urandom_range(0, 7);
        ret_regid[p*5 +: 5] = 5'(id);
        ret_valid[p] = ((cnt_m[id] > 0) && ($urandom_range(0, 2) == 0)) ||
                       ($urandom_range(0, 63) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
